// File: rtl/debounce_pkg.sv
// Shared types and defaults for the button debouncer.
//   db_state_t      : debouncer FSM state encoding
//   DB_TICK_DIV_DEF : default clocks per sample tick (1 ms at 50 MHz)
//   DB_STABLE_N_DEF : default number of agreeing samples to change level
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PENDING,
    PRESSED,
    RELEASE_PENDING
  } db_state_t;

  localparam int DB_TICK_DIV_DEF = 50000;
  localparam int DB_STABLE_N_DEF = 16;

endpackage

// File: rtl/tick_gen.sv
// Sample-strobe prescaler. Counts 0..TICK_DIV-1 and wraps; tick is the
// registered wrap decode, so the first strobe appears on the TICK_DIV-th
// rising edge after reset and then every TICK_DIV cycles.
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   tick : one-cycle sample strobe
module tick_gen
  import debounce_pkg::*;
#(
  parameter int TICK_DIV = DB_TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Debouncer for one mechanical push-button. The raw pin is synchronized,
// polarity-normalized and sampled on the prescaler tick; the debounced level
// changes only after STABLE_N consecutive samples disagree with it.
// Ports:
//   clk           : system clock
//   rstn          : asynchronous active-low reset
//   btn_raw       : asynchronous button pin
//   level         : debounced state, 1 = pressed
//   press         : one-cycle pulse when level rises
//   release_pulse : one-cycle pulse when level falls (`release` is a
//                   reserved word in SystemVerilog)
//   tick          : sample strobe, exported for reuse
//
// state           | meaning
// RELEASED        | level 0, run counter 0
// PRESS_PENDING   | level 0, >=1 pressed sample seen in current run
// PRESSED         | level 1, run counter 0
// RELEASE_PENDING | level 1, >=1 released sample seen in current run
module btn_debounce
  import debounce_pkg::*;
#(
  parameter int TICK_DIV   = DB_TICK_DIV_DEF,
  parameter int STABLE_N   = DB_STABLE_N_DEF,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic tick
);

  localparam int                CNT_W    = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Raw pin value meaning "not pressed"; the synchronizer resets to it so
  // leaving reset never looks like a press.
  localparam logic RAW_IDLE = (ACTIVE_LOW != 0);

  logic             sync1;
  logic             sync2;
  logic             btn_s;
  logic [CNT_W-1:0] cnt;
  db_state_t        state;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= RAW_IDLE;
      sync2 <= RAW_IDLE;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign btn_s = sync2 ^ RAW_IDLE;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= RELEASED;
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      if (tick) begin
        unique case (state)
          RELEASED: begin
            if (btn_s) begin
              // CNT_LAST is 0 only when a single sample completes the run.
              if (CNT_LAST == '0) begin
                state <= PRESSED;
                level <= 1'b1;
                press <= 1'b1;
              end else begin
                cnt   <= CNT_ONE;
                state <= PRESS_PENDING;
              end
            end
          end
          PRESS_PENDING: begin
            if (!btn_s) begin
              cnt   <= '0;
              state <= RELEASED;
            end else if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= PRESSED;
              level <= 1'b1;
              press <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          PRESSED: begin
            if (!btn_s) begin
              if (CNT_LAST == '0) begin
                state         <= RELEASED;
                level         <= 1'b0;
                release_pulse <= 1'b1;
              end else begin
                cnt   <= CNT_ONE;
                state <= RELEASE_PENDING;
              end
            end
          end
          RELEASE_PENDING: begin
            if (btn_s) begin
              cnt   <= '0;
              state <= PRESSED;
            end else if (cnt == CNT_LAST) begin
              cnt           <= '0;
              state         <= RELEASED;
              level         <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            cnt   <= '0;
            state <= RELEASED;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce. Main instance: TICK_DIV=4, STABLE_N=3,
// active-low. Second instance: TICK_DIV=2, STABLE_N=1 under a square wave.
// Cycle numbers below count rising edges since the latest reset release.
module tb_btn_debounce;

  logic clk;
  logic rstn, btn_raw, level, press, rel, tick;
  logic rstn_e, btn_e, level_e, press_e, rel_e, tick_e;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  int n_press_m = 0, n_rel_m = 0, viol_m = 0;
  int n_press_e = 0, n_rel_e = 0, viol_e = 0;
  logic press_q = 0, rel_q = 0, level_q = 0, rstn_q = 0;
  logic press_eq = 0, rel_eq = 0, level_eq = 0, rstn_eq = 0;

  btn_debounce #(
    .TICK_DIV   (4),
    .STABLE_N   (3),
    .ACTIVE_LOW (1)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .btn_raw       (btn_raw),
    .level         (level),
    .press         (press),
    .release_pulse (rel),
    .tick          (tick)
  );

  btn_debounce #(
    .TICK_DIV   (2),
    .STABLE_N   (1),
    .ACTIVE_LOW (1)
  ) dut_e (
    .clk           (clk),
    .rstn          (rstn_e),
    .btn_raw       (btn_e),
    .level         (level_e),
    .press         (press_e),
    .release_pulse (rel_e),
    .tick          (tick_e)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse-shape monitors: exclusivity, single-cycle width, and pulses
  // coinciding with level edges.
  always @(negedge clk) begin
    if (rstn && rstn_q) begin
      if (press && rel) viol_m++;
      if (press && press_q) viol_m++;
      if (rel && rel_q) viol_m++;
      if (press !== (level && !level_q)) viol_m++;
      if (rel !== (!level && level_q)) viol_m++;
    end
    if (press) n_press_m++;
    if (rel) n_rel_m++;
    press_q = press; rel_q = rel; level_q = level; rstn_q = rstn;
  end

  always @(negedge clk) begin
    if (rstn_e && rstn_eq) begin
      if (press_e && rel_e) viol_e++;
      if (press_e && press_eq) viol_e++;
      if (rel_e && rel_eq) viol_e++;
      if (press_e !== (level_e && !level_eq)) viol_e++;
      if (rel_e !== (!level_e && level_eq)) viol_e++;
    end
    if (press_e) n_press_e++;
    if (rel_e) n_rel_e++;
    press_eq = press_e; rel_eq = rel_e; level_eq = level_e; rstn_eq = rstn_e;
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  logic       bounce_s [0:5];
  logic       hist [0:63];
  logic       exp_lvl, prev_lvl;

  initial begin
    bounce_s[0] = 1'b0; bounce_s[1] = 1'b0; bounce_s[2] = 1'b1;
    bounce_s[3] = 1'b0; bounce_s[4] = 1'b0; bounce_s[5] = 1'b0;
    for (int i = 0; i < 64; i++) hist[i] = 1'b1;

    rstn = 1'b0; btn_raw = 1'b1;
    rstn_e = 1'b0; btn_e = 1'b1;

    // Reset, input idle
    repeat (3) @(posedge clk);
    #1;
    chk_bit("rst_level", level, 1'b0);
    chk_bit("rst_press", press, 1'b0);
    chk_bit("rst_release", rel, 1'b0);
    chk_bit("rst_tick", tick, 1'b0);
    rstn = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 100; k++) begin
      run_to(k);
      chk_bit("idle_tick", tick, (k % 4) == 0);
      chk_bit("idle_level", level, 1'b0);
      chk_bit("idle_press", press, 1'b0);
      chk_bit("idle_release", rel, 1'b0);
    end

    // Clean press: btn_s rises after edge 102, evaluations at 105/109/113
    btn_raw = 1'b0;
    run_to(112);
    chk_bit("press_early_level", level, 1'b0);
    run_to(113);
    chk_bit("press_level", level, 1'b1);
    chk_bit("press_pulse", press, 1'b1);
    chk_bit("press_no_release", rel, 1'b0);
    run_to(114);
    chk_bit("press_pulse_end", press, 1'b0);
    chk_bit("press_level_hold", level, 1'b1);

    // Sub-tick glitches while pressed, placed to miss every tick sample
    run_to(115); btn_raw = 1'b1;
    run_to(117); btn_raw = 1'b0;
    run_to(119); btn_raw = 1'b1;
    run_to(120); btn_raw = 1'b0;
    run_to(124);
    chk_bit("glitch_level", level, 1'b1);
    chk_int("glitch_no_release", n_rel_m, 0);

    // Release: btn_s falls after 126, evaluations at 129/133/137
    btn_raw = 1'b1;
    run_to(136);
    chk_bit("release_early_level", level, 1'b1);
    run_to(137);
    chk_bit("release_level", level, 1'b0);
    chk_bit("release_pulse", rel, 1'b1);
    chk_bit("release_no_press", press, 1'b0);
    run_to(138);
    chk_bit("release_pulse_end", rel, 1'b0);

    // Reset mid-run: two pressed samples (145, 149), reset while tick high
    run_to(140); btn_raw = 1'b0;
    run_to(152);
    chk_bit("midrst_pre_level", level, 1'b0);
    chk_bit("midrst_pre_tick", tick, 1'b1);
    rstn = 1'b0;
    #1;
    chk_bit("midrst_level", level, 1'b0);
    chk_bit("midrst_press", press, 1'b0);
    chk_bit("midrst_release", rel, 1'b0);
    chk_bit("midrst_tick", tick, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc = 0;
    run_to(5);
    chk_bit("midrst_after_first", level, 1'b0);
    run_to(12);
    chk_bit("midrst_early_level", level, 1'b0);
    chk_int("midrst_press_count", n_press_m, 1);
    run_to(13);
    chk_bit("midrst_press", press, 1'b1);
    chk_bit("midrst_level_up", level, 1'b1);

    // Release again to get back to RELEASED (evaluations at 21/25/29)
    run_to(16); btn_raw = 1'b1;
    run_to(28);
    chk_bit("rel2_early_level", level, 1'b1);
    run_to(29);
    chk_bit("rel2_pulse", rel, 1'b1);
    chk_bit("rel2_level", level, 1'b0);

    // Bounce: raw samples 0,0,1,0,0,0 at evaluations 33..53
    for (int i = 0; i < 6; i++) begin
      run_to(30 + 4 * i);
      btn_raw = bounce_s[i];
      run_to(33 + 4 * i);
      chk_bit("bounce_level", level, i == 5);
      chk_bit("bounce_press", press, i == 5);
    end
    run_to(60);
    chk_int("main_press_total", n_press_m, 3);
    chk_int("main_release_total", n_rel_m, 2);
    chk_int("main_pulse_violations", viol_m, 0);

    // STABLE_N=1, TICK_DIV=2: level follows the sample taken 3 edges earlier
    @(posedge clk);
    #1;
    rstn_e = 1'b1;
    cyc = 0;
    hist[0] = btn_e;
    exp_lvl = 1'b0;
    prev_lvl = 1'b0;
    for (int j = 1; j <= 52; j++) begin
      run_to(j);
      if ((j % 2) == 1 && j >= 3) exp_lvl = ~hist[j - 3];
      chk_bit("edge_level", level_e, exp_lvl);
      chk_bit("edge_press", press_e, exp_lvl & ~prev_lvl);
      chk_bit("edge_release", rel_e, ~exp_lvl & prev_lvl);
      chk_bit("edge_tick", tick_e, (j % 2) == 0);
      prev_lvl = exp_lvl;
      btn_e = (j >= 10 && j <= 49 && ((j / 5) % 2) == 0) ? 1'b0 : 1'b1;
      hist[j] = btn_e;
    end
    run_to(54);
    chk_int("edge_press_total", n_press_e, 4);
    chk_int("edge_release_total", n_rel_e, 4);
    chk_int("edge_pulse_violations", viol_e, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
